// File: rtl/rest_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package rest_serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rest_comp.sv
// Combinational 1-bit full subtractor: diff = x - y - bi, bo is the borrow out.
module rest_comp
   import rest_serial_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic diff,
   output logic bo
);

   assign diff = x ^ y ^ bi;
   assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/rest_serial.sv
// Bit-serial WIDTH-bit subtractor d = a - b, LSB first, one bit per clock, with a
// start/busy/done handshake. Result, borrow and signed overflow are registered.
module rest_serial
   import rest_serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_d;
   logic             r_busy;
   logic             r_done;
   logic             r_bout;
   logic             r_ovf;

   logic             w_diff;
   logic             w_bo;
   logic [WIDTH-1:0] w_res_next;

   rest_comp u_comp (
      .x    (r_sa[0]),
      .y    (r_sb[0]),
      .bi   (r_borrow),
      .diff (w_diff),
      .bo   (w_bo)
   );

   assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

   // NOTE: every register in this block uses <= so all updates see the pre-edge values;
   // a blocking = here would let the shift and the borrow race within one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_d      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_sa     <= a;
                  r_sb     <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end

            ST_RUN: begin
               r_sa     <= r_sa >> 1;
               r_sb     <= r_sb >> 1;
               r_res    <= w_res_next;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CW'(1);
               // Last bit: the operand LSBs now hold the original MSBs, used for overflow.
               if (r_cnt == LAST_BIT) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_d     <= w_res_next;
                  r_bout  <= w_bo;
                  r_ovf   <= (r_sa[0] ^ r_sb[0]) & (r_sa[0] ^ w_diff);
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign bout = r_bout;
   assign ovf  = r_ovf;

endmodule
